router_egress_arbiter: RTL and testbench

//  Packet-atomic round-robin arbiter draining the three router output FIFOs onto one shared egress port.

---
 rtl/router_egress_arbiter_if.sv | 23 ++
 rtl/router_egress_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_router_egress_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/router_egress_arbiter_if.sv
// Egress-side bus of the router egress arbiter: byte stream with valid/ready
// handshake, packet framing flags, source channel and abort indication.
interface router_egress_arbiter_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] eg_data;
    logic              eg_valid;
    logic              eg_ready;
    logic              eg_sop;
    logic              eg_eop;
    logic [1:0]        eg_chan;
    logic              abort;

    modport master (
        output eg_data, eg_valid, eg_sop, eg_eop, eg_chan, abort,
        input  eg_ready
    );

    modport slave (
        input  eg_data, eg_valid, eg_sop, eg_eop, eg_chan, abort,
        output eg_ready
    );
endinterface

// File: rtl/router_egress_arbiter.sv
// Packet-atomic round-robin arbiter draining three router FIFOs onto one
// egress port through a 2-entry buffer, with stall-timeout abort.
module router_egress_arbiter #(
    parameter int DATA_W    = 8,
    parameter int STALL_MAX = 32
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    vld_out_0,
    input  logic                    vld_out_1,
    input  logic                    vld_out_2,
    input  logic [DATA_W-1:0]       d_out_0,
    input  logic [DATA_W-1:0]       d_out_1,
    input  logic [DATA_W-1:0]       d_out_2,
    output logic                    rd_enb_0,
    output logic                    rd_enb_1,
    output logic                    rd_enb_2,
    router_egress_arbiter_if.master eg
);
    localparam int REM_W = DATA_W - 1;
    localparam int STL_W = $clog2(STALL_MAX + 1);

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_HCAP, S_BODY, S_WAIT} state_t;

    state_t            r_state, w_state_nxt;
    logic [1:0]        r_chan, w_chan_nxt;
    logic [1:0]        r_ptr, w_ptr_nxt;
    logic [REM_W-1:0]  r_rem, w_rem_nxt;
    logic [STL_W-1:0]  r_stall, w_stall_nxt;
    logic              r_if, r_if_sop, r_if_eop, r_abort;
    logic [DATA_W+1:0] r_buf [2];
    logic              r_wp, r_rp;
    logic [1:0]        r_cnt;

    logic              w_rd, w_rd_sop, w_rd_eop, w_abort, w_stalling, w_stall_hit;
    logic              w_vsel, w_valid, w_pop, w_eop_acc, w_credit;
    logic [DATA_W-1:0] w_dsel;
    logic [DATA_W+1:0] w_head;
    logic [1:0]        w_c0, w_c1, w_c2, w_next_ch;
    logic [2:0]        w_vld;

    assign w_vld = {vld_out_2, vld_out_1, vld_out_0};

    always_comb begin
        w_vsel = vld_out_0;
        w_dsel = d_out_0;
        case (r_chan)
            2'd1:    begin w_vsel = vld_out_1; w_dsel = d_out_1; end
            2'd2:    begin w_vsel = vld_out_2; w_dsel = d_out_2; end
            default: begin w_vsel = vld_out_0; w_dsel = d_out_0; end
        endcase
    end

    always_comb begin
        w_c0 = 2'd0; w_c1 = 2'd1; w_c2 = 2'd2;
        case (r_ptr)
            2'd1:    begin w_c0 = 2'd1; w_c1 = 2'd2; w_c2 = 2'd0; end
            2'd2:    begin w_c0 = 2'd2; w_c1 = 2'd0; w_c2 = 2'd1; end
            default: begin w_c0 = 2'd0; w_c1 = 2'd1; w_c2 = 2'd2; end
        endcase
    end

    assign w_head    = r_buf[r_rp];
    assign w_valid   = (r_cnt != 2'd0);
    assign w_pop     = w_valid & eg.eg_ready;
    assign w_eop_acc = w_pop & w_head[0];
    // Reads in flight count against the buffer so a pop is never required to avoid overflow
    assign w_credit    = ((r_cnt + {1'b0, r_if}) < 2'd2);
    assign w_next_ch   = (r_chan == 2'd2) ? 2'd0 : r_chan + 2'd1;
    assign w_stall_hit = (r_stall == STL_W'(STALL_MAX - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_chan_nxt  = r_chan;
        w_ptr_nxt   = r_ptr;
        w_rem_nxt   = r_rem;
        w_stall_nxt = r_stall;
        w_rd        = 1'b0;
        w_rd_sop    = 1'b0;
        w_rd_eop    = 1'b0;
        w_abort     = 1'b0;
        w_stalling  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_stall_nxt = '0;
                if (w_vld[w_c0]) begin
                    w_chan_nxt = w_c0; w_state_nxt = S_HDR;
                end else if (w_vld[w_c1]) begin
                    w_chan_nxt = w_c1; w_state_nxt = S_HDR;
                end else if (w_vld[w_c2]) begin
                    w_chan_nxt = w_c2; w_state_nxt = S_HDR;
                end
            end
            S_HDR: begin
                if (w_vsel) begin
                    w_stall_nxt = '0;
                    if (w_credit) begin
                        w_rd = 1'b1; w_rd_sop = 1'b1; w_state_nxt = S_HCAP;
                    end
                end else begin
                    w_stalling = 1'b1;
                end
            end
            S_HCAP: begin
                // Header arrives now: payload length plus the parity byte remain
                w_rem_nxt   = REM_W'(w_dsel[DATA_W-1:2]) + REM_W'(1);
                w_state_nxt = S_BODY;
            end
            S_BODY: begin
                if (w_vsel) begin
                    w_stall_nxt = '0;
                    if (w_credit) begin
                        w_rd      = 1'b1;
                        w_rem_nxt = r_rem - REM_W'(1);
                        if (r_rem == REM_W'(1)) begin
                            w_rd_eop = 1'b1; w_state_nxt = S_WAIT;
                        end
                    end
                end else begin
                    w_stalling = 1'b1;
                end
            end
            S_WAIT: begin
                if (w_eop_acc) begin
                    w_ptr_nxt = w_next_ch; w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_stalling) begin
            if (w_stall_hit) begin
                w_abort     = 1'b1;
                w_ptr_nxt   = w_next_ch;
                w_state_nxt = S_IDLE;
                w_stall_nxt = '0;
            end else begin
                w_stall_nxt = r_stall + STL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= S_IDLE;
            r_chan   <= '0;
            r_ptr    <= '0;
            r_rem    <= '0;
            r_stall  <= '0;
            r_if     <= 1'b0;
            r_if_sop <= 1'b0;
            r_if_eop <= 1'b0;
            r_abort  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_chan   <= w_chan_nxt;
            r_ptr    <= w_ptr_nxt;
            r_rem    <= w_rem_nxt;
            r_stall  <= w_stall_nxt;
            r_if     <= w_rd;
            r_if_sop <= w_rd_sop;
            r_if_eop <= w_rd_eop;
            r_abort  <= w_abort;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < 2; i++) r_buf[i] <= '0;
            r_wp  <= 1'b0;
            r_rp  <= 1'b0;
            r_cnt <= '0;
        end else if (w_abort) begin
            r_wp  <= 1'b0;
            r_rp  <= 1'b0;
            r_cnt <= '0;
        end else begin
            if (r_if) begin
                r_buf[r_wp] <= {w_dsel, r_if_sop, r_if_eop};
                r_wp        <= ~r_wp;
            end
            if (w_pop) r_rp <= ~r_rp;
            case ({r_if, w_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign rd_enb_0    = w_rd & (r_chan == 2'd0);
    assign rd_enb_1    = w_rd & (r_chan == 2'd1);
    assign rd_enb_2    = w_rd & (r_chan == 2'd2);
    assign eg.eg_valid = w_valid;
    assign eg.eg_data  = w_valid ? w_head[DATA_W+1:2] : '0;
    assign eg.eg_sop   = w_valid & w_head[1];
    assign eg.eg_eop   = w_valid & w_head[0];
    assign eg.eg_chan  = r_chan;
    assign eg.abort    = r_abort;
endmodule

// File: tb/tb_router_egress_arbiter.sv
// Directed self-checking bench for router_egress_arbiter: FIFO models feed the
// three channels, a monitor records accepted egress bytes for comparison.
module tb_router_egress_arbiter;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rstn;
    logic          vld_out_0, vld_out_1, vld_out_2;
    logic [DW-1:0] d_out_0 = '0, d_out_1 = '0, d_out_2 = '0;
    logic          rd_enb_0, rd_enb_1, rd_enb_2;

    router_egress_arbiter_if #(.DATA_W(DW)) eg ();

    router_egress_arbiter #(.DATA_W(DW), .STALL_MAX(32)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .vld_out_0 (vld_out_0),
        .vld_out_1 (vld_out_1),
        .vld_out_2 (vld_out_2),
        .d_out_0   (d_out_0),
        .d_out_1   (d_out_1),
        .d_out_2   (d_out_2),
        .rd_enb_0  (rd_enb_0),
        .rd_enb_1  (rd_enb_1),
        .rd_enb_2  (rd_enb_2),
        .eg        (eg)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // FIFO models: bytes written by the stimulus, popped on rd_enb
    logic [7:0] mem [3][256];
    int wp [3] = '{0, 0, 0};
    int rp [3] = '{0, 0, 0};
    int rdcnt [3] = '{0, 0, 0};
    int viol = 0;

    assign vld_out_0 = (wp[0] != rp[0]);
    assign vld_out_1 = (wp[1] != rp[1]);
    assign vld_out_2 = (wp[2] != rp[2]);

    always @(posedge clk) begin
        if (rd_enb_0) begin d_out_0 <= mem[0][rp[0] % 256]; rp[0] <= rp[0] + 1; rdcnt[0] <= rdcnt[0] + 1; end
        if (rd_enb_1) begin d_out_1 <= mem[1][rp[1] % 256]; rp[1] <= rp[1] + 1; rdcnt[1] <= rdcnt[1] + 1; end
        if (rd_enb_2) begin d_out_2 <= mem[2][rp[2] % 256]; rp[2] <= rp[2] + 1; rdcnt[2] <= rdcnt[2] + 1; end
        if ((int'(rd_enb_0) + int'(rd_enb_1) + int'(rd_enb_2)) > 1 ||
            (rd_enb_0 && !vld_out_0) || (rd_enb_1 && !vld_out_1) || (rd_enb_2 && !vld_out_2))
            viol <= viol + 1;
    end

    // Egress monitor
    logic [7:0] cap_d [512];
    logic       cap_s [512];
    logic       cap_e [512];
    logic [1:0] cap_c [512];
    int ncap = 0;
    int nabort = 0;

    always @(negedge clk) begin
        if (rstn && eg.eg_valid && eg.eg_ready) begin
            cap_d[ncap] <= eg.eg_data;
            cap_s[ncap] <= eg.eg_sop;
            cap_e[ncap] <= eg.eg_eop;
            cap_c[ncap] <= eg.eg_chan;
            ncap        <= ncap + 1;
        end
        if (rstn && eg.abort) nabort <= nabort + 1;
    end

    // Expected egress stream
    logic [7:0] exp_d [512];
    logic       exp_s [512];
    logic       exp_e [512];
    logic [1:0] exp_c [512];
    int nexp = 0;

    task automatic load_pkt(input int ch, input int len, input int nload, input int nexpb);
        logic [7:0] b [0:65];
        logic [7:0] par;
        logic [5:0] l6;
        l6   = 6'(len);
        b[0] = {l6, 2'(ch)};
        par  = b[0];
        for (int i = 1; i <= len; i++) begin
            b[i] = 8'(48 + ch * 64 + i * 5);
            par  = par ^ b[i];
        end
        b[len+1] = par;
        for (int i = 0; i < nload; i++) begin
            mem[ch][wp[ch] % 256] = b[i];
            wp[ch] = wp[ch] + 1;
        end
        for (int i = 0; i < nexpb; i++) begin
            exp_d[nexp] = b[i];
            exp_s[nexp] = (i == 0);
            exp_e[nexp] = (i == len + 1);
            exp_c[nexp] = 2'(ch);
            nexp = nexp + 1;
        end
    endtask

    task automatic test_reset();
        int cb, eb;
        rstn = 1'b0;
        eg.eg_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({rd_enb_2, rd_enb_1, rd_enb_0, eg.eg_valid, eg.eg_sop, eg.eg_eop, eg.eg_data, eg.eg_chan, eg.abort} !== '0) begin
            failures++;
            $display("FAIL reset_state: got rd=%b%b%b v=%b s=%b e=%b d=%h c=%0d a=%b expected all zero",
                     rd_enb_2, rd_enb_1, rd_enb_0, eg.eg_valid, eg.eg_sop, eg.eg_eop, eg.eg_data, eg.eg_chan, eg.abort);
        end
        rstn = 1'b1;
        // Stall the egress so the packet is caught mid-body
        eg.eg_ready = 1'b0;
        load_pkt(0, 6, 8, 0);
        for (int c = 0; c < 50 && !eg.eg_valid; c++) begin @(posedge clk); #1; end
        checks++;
        if (eg.eg_valid !== 1'b1) begin
            failures++; $display("FAIL reset_prefill: got eg_valid=%b expected 1", eg.eg_valid);
        end
        repeat (4) @(posedge clk);
        #3 rstn = 1'b0;
        #1;
        checks++;
        if ({rd_enb_2, rd_enb_1, rd_enb_0, eg.eg_valid, eg.eg_sop, eg.eg_eop, eg.eg_data, eg.eg_chan, eg.abort} !== '0) begin
            failures++;
            $display("FAIL reset_async: got rd=%b%b%b v=%b s=%b e=%b d=%h c=%0d a=%b expected all zero",
                     rd_enb_2, rd_enb_1, rd_enb_0, eg.eg_valid, eg.eg_sop, eg.eg_eop, eg.eg_data, eg.eg_chan, eg.abort);
        end
        for (int k = 0; k < 3; k++) wp[k] = rp[k];
        @(posedge clk); #1;
        rstn = 1'b1;
        eg.eg_ready = 1'b1;
        cb = ncap; eb = nexp;
        load_pkt(0, 2, 4, 4);
        load_pkt(1, 2, 4, 4);
        load_pkt(2, 2, 4, 4);
        for (int c = 0; c < 300 && (ncap - cb) < 12; c++) begin @(posedge clk); #1; end
        checks++;
        if (ncap - cb != 12) begin failures++; $display("FAIL reset_count: got %0d bytes expected 12", ncap - cb); end
        checks++;
        if (cap_c[cb] !== 2'd0) begin failures++; $display("FAIL reset_first_grant: got chan %0d expected 0", cap_c[cb]); end
        for (int i = 0; i < 12; i++) begin
            checks++;
            if ({cap_d[cb+i], cap_s[cb+i], cap_e[cb+i], cap_c[cb+i]} !== {exp_d[eb+i], exp_s[eb+i], exp_e[eb+i], exp_c[eb+i]}) begin
                failures++;
                $display("FAIL reset_byte%0d: got d=%h s=%b e=%b c=%0d expected d=%h s=%b e=%b c=%0d", i,
                         cap_d[cb+i], cap_s[cb+i], cap_e[cb+i], cap_c[cb+i], exp_d[eb+i], exp_s[eb+i], exp_e[eb+i], exp_c[eb+i]);
            end
        end
    endtask

    task automatic test_single_ch0();
        int cb, eb, rb;
        @(posedge clk); #1;
        cb = ncap; eb = nexp; rb = rdcnt[0];
        load_pkt(0, 2, 4, 4);
        for (int c = 0; c < 100 && (ncap - cb) < 4; c++) begin @(posedge clk); #1; end
        repeat (3) @(posedge clk); #1;
        checks++;
        if (ncap - cb != 4) begin failures++; $display("FAIL single_count: got %0d bytes expected 4", ncap - cb); end
        checks++;
        if (rdcnt[0] - rb != 4) begin failures++; $display("FAIL single_rd0: got %0d pulses expected 4", rdcnt[0] - rb); end
        checks++;
        if (cap_d[cb] !== 8'h08) begin failures++; $display("FAIL single_hdr: got %h expected 08", cap_d[cb]); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({cap_d[cb+i], cap_s[cb+i], cap_e[cb+i], cap_c[cb+i]} !== {exp_d[eb+i], exp_s[eb+i], exp_e[eb+i], exp_c[eb+i]}) begin
                failures++;
                $display("FAIL single_byte%0d: got d=%h s=%b e=%b c=%0d expected d=%h s=%b e=%b c=%0d", i,
                         cap_d[cb+i], cap_s[cb+i], cap_e[cb+i], cap_c[cb+i], exp_d[eb+i], exp_s[eb+i], exp_e[eb+i], exp_c[eb+i]);
            end
        end
    endtask

    task automatic test_len0_ch1();
        int cb, eb, rb;
        @(posedge clk); #1;
        cb = ncap; eb = nexp; rb = rdcnt[1];
        load_pkt(1, 0, 2, 2);
        for (int c = 0; c < 100 && (ncap - cb) < 2; c++) begin @(posedge clk); #1; end
        repeat (3) @(posedge clk); #1;
        checks++;
        if (ncap - cb != 2) begin failures++; $display("FAIL len0_count: got %0d bytes expected 2", ncap - cb); end
        checks++;
        if (rdcnt[1] - rb != 2) begin failures++; $display("FAIL len0_rd1: got %0d pulses expected 2", rdcnt[1] - rb); end
        checks++;
        if (cap_d[cb] !== 8'h01) begin failures++; $display("FAIL len0_hdr: got %h expected 01", cap_d[cb]); end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({cap_d[cb+i], cap_s[cb+i], cap_e[cb+i], cap_c[cb+i]} !== {exp_d[eb+i], exp_s[eb+i], exp_e[eb+i], exp_c[eb+i]}) begin
                failures++;
                $display("FAIL len0_byte%0d: got d=%h s=%b e=%b c=%0d expected d=%h s=%b e=%b c=%0d", i,
                         cap_d[cb+i], cap_s[cb+i], cap_e[cb+i], cap_c[cb+i], exp_d[eb+i], exp_s[eb+i], exp_e[eb+i], exp_c[eb+i]);
            end
        end
    endtask

    task automatic test_ready_toggle();
        int cb, eb, rb, unstable, maxocc, occ;
        logic       pv, pr, ps, pe;
        logic [7:0] pd;
        @(posedge clk); #1;
        cb = ncap; eb = nexp; rb = rdcnt[0] + rdcnt[1] + rdcnt[2];
        unstable = 0; maxocc = 0;
        pv = 1'b0; pr = 1'b1; pd = '0; ps = 1'b0; pe = 1'b0;
        load_pkt(2, 4, 6, 6);
        for (int c = 0; c < 200 && (ncap - cb) < 6; c++) begin
            eg.eg_ready = ~eg.eg_ready;
            #2;
            if (pv && !pr && (eg.eg_valid !== 1'b1 || eg.eg_data !== pd || eg.eg_sop !== ps || eg.eg_eop !== pe))
                unstable++;
            occ = (rdcnt[0] + rdcnt[1] + rdcnt[2] - rb) - (ncap - cb);
            if (occ > maxocc) maxocc = occ;
            pv = eg.eg_valid; pr = eg.eg_ready; pd = eg.eg_data; ps = eg.eg_sop; pe = eg.eg_eop;
            @(posedge clk); #1;
        end
        eg.eg_ready = 1'b1;
        repeat (3) @(posedge clk); #1;
        checks++;
        if (ncap - cb != 6) begin failures++; $display("FAIL toggle_count: got %0d bytes expected 6", ncap - cb); end
        checks++;
        if (unstable != 0) begin failures++; $display("FAIL toggle_stable: got %0d changes while stalled expected 0", unstable); end
        checks++;
        if (maxocc > 2) begin failures++; $display("FAIL toggle_occupancy: got %0d outstanding expected <=2", maxocc); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if ({cap_d[cb+i], cap_s[cb+i], cap_e[cb+i], cap_c[cb+i]} !== {exp_d[eb+i], exp_s[eb+i], exp_e[eb+i], exp_c[eb+i]}) begin
                failures++;
                $display("FAIL toggle_byte%0d: got d=%h s=%b e=%b c=%0d expected d=%h s=%b e=%b c=%0d", i,
                         cap_d[cb+i], cap_s[cb+i], cap_e[cb+i], cap_c[cb+i], exp_d[eb+i], exp_s[eb+i], exp_e[eb+i], exp_c[eb+i]);
            end
        end
    endtask

    task automatic test_three_way();
        int cb, eb;
        @(posedge clk); #1;
        cb = ncap; eb = nexp;
        load_pkt(0, 2, 4, 4);
        load_pkt(1, 4, 6, 6);
        load_pkt(2, 6, 8, 8);
        for (int c = 0; c < 300 && (ncap - cb) < 18; c++) begin @(posedge clk); #1; end
        checks++;
        if (ncap - cb != 18) begin failures++; $display("FAIL three_count: got %0d bytes expected 18", ncap - cb); end
        for (int i = 0; i < 18; i++) begin
            checks++;
            if ({cap_d[cb+i], cap_s[cb+i], cap_e[cb+i], cap_c[cb+i]} !== {exp_d[eb+i], exp_s[eb+i], exp_e[eb+i], exp_c[eb+i]}) begin
                failures++;
                $display("FAIL three_byte%0d: got d=%h s=%b e=%b c=%0d expected d=%h s=%b e=%b c=%0d", i,
                         cap_d[cb+i], cap_s[cb+i], cap_e[cb+i], cap_c[cb+i], exp_d[eb+i], exp_s[eb+i], exp_e[eb+i], exp_c[eb+i]);
            end
        end
        // Pointer wrapped past ch2: ch0 wins over ch1
        cb = ncap;
        load_pkt(0, 1, 3, 3);
        load_pkt(1, 1, 3, 3);
        for (int c = 0; c < 100 && (ncap - cb) < 6; c++) begin @(posedge clk); #1; end
        repeat (3) @(posedge clk); #1;
        checks++;
        if (ncap - cb != 6) begin failures++; $display("FAIL wrap_count: got %0d bytes expected 6", ncap - cb); end
        checks++;
        if (cap_c[cb] !== 2'd0 || cap_c[cb+3] !== 2'd1) begin
            failures++; $display("FAIL wrap_order: got chans %0d,%0d expected 0,1", cap_c[cb], cap_c[cb+3]);
        end
    endtask

    task automatic test_stall_abort();
        int cb, eb, ab, cyc;
        @(posedge clk); #1;
        cb = ncap; eb = nexp; ab = nabort;
        load_pkt(2, 4, 2, 2);
        cyc = 0;
        for (int c = 0; c < 100 && nabort == ab; c++) begin @(posedge clk); #1; cyc++; end
        repeat (40) @(posedge clk); #1;
        checks++;
        if (nabort - ab != 1) begin failures++; $display("FAIL stall_abort_pulses: got %0d expected 1", nabort - ab); end
        checks++;
        if (cyc < 33 || cyc > 45) begin failures++; $display("FAIL stall_abort_time: got %0d cycles expected 33..45", cyc); end
        checks++;
        if (ncap - cb != 2) begin failures++; $display("FAIL stall_count: got %0d bytes expected 2", ncap - cb); end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({cap_d[cb+i], cap_s[cb+i], cap_e[cb+i], cap_c[cb+i]} !== {exp_d[eb+i], exp_s[eb+i], exp_e[eb+i], exp_c[eb+i]}) begin
                failures++;
                $display("FAIL stall_byte%0d: got d=%h s=%b e=%b c=%0d expected d=%h s=%b e=%b c=%0d", i,
                         cap_d[cb+i], cap_s[cb+i], cap_e[cb+i], cap_c[cb+i], exp_d[eb+i], exp_s[eb+i], exp_e[eb+i], exp_c[eb+i]);
            end
        end
        // After abort on ch2 the pointer sits at ch0
        cb = ncap; eb = nexp;
        load_pkt(0, 0, 2, 2);
        load_pkt(1, 0, 2, 2);
        load_pkt(2, 0, 2, 2);
        for (int c = 0; c < 100 && (ncap - cb) < 6; c++) begin @(posedge clk); #1; end
        checks++;
        if (ncap - cb != 6) begin failures++; $display("FAIL post_abort_count: got %0d bytes expected 6", ncap - cb); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if ({cap_d[cb+i], cap_s[cb+i], cap_e[cb+i], cap_c[cb+i]} !== {exp_d[eb+i], exp_s[eb+i], exp_e[eb+i], exp_c[eb+i]}) begin
                failures++;
                $display("FAIL post_abort_byte%0d: got d=%h s=%b e=%b c=%0d expected d=%h s=%b e=%b c=%0d", i,
                         cap_d[cb+i], cap_s[cb+i], cap_e[cb+i], cap_c[cb+i], exp_d[eb+i], exp_s[eb+i], exp_e[eb+i], exp_c[eb+i]);
            end
        end
        checks++;
        if (viol != 0) begin failures++; $display("FAIL rd_enb_rules: got %0d violations expected 0", viol); end
    endtask

    initial begin
        eg.eg_ready = 1'b1;
        test_reset();
        test_single_ch0();
        test_len0_ch1();
        test_ready_toggle();
        test_three_way();
        test_stall_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
